// File: rtl/tx_byte_sequencer_if.sv
// Handshake bundle between the result byte sequencer, the output stage and the UART.
// master = sequencer side, slave = output stage / UART side.
interface tx_byte_sequencer_if;
    logic result_valid;
    logic tx_busy;
    logic register_result32;
    logic send_b0;
    logic send_b1;
    logic send_b2;
    logic send_b3;
    logic tx_start;
    logic seq_busy;
    logic done;
    logic overrun;
    logic ack_err;

    modport master (
        input  result_valid, tx_busy,
        output register_result32, send_b0, send_b1, send_b2, send_b3,
               tx_start, seq_busy, done, overrun, ack_err
    );

    modport slave (
        output result_valid, tx_busy,
        input  register_result32, send_b0, send_b1, send_b2, send_b3,
               tx_start, seq_busy, done, overrun, ack_err
    );
endinterface

// File: rtl/tx_byte_sequencer.sv
// Serialises a latched 32-bit result into four UART bytes with ack timeout and inter-byte gap.
// Optional macro TX_SEQ_MSB_FIRST_EN: send b3..b0 instead of the default b0..b3.
module tx_byte_sequencer #(
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    tx_byte_sequencer_if.master bus
);
    localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1) + 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LATCH     = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] WAIT_ACK  = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] GAP       = 3'd5;
    localparam logic [2:0] FINISH    = 3'd6;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [2:0]    after_byte;
    logic [1:0]    idx;
    logic [1:0]    sel;
    logic [CW-1:0] cnt;
    logic [3:0]    send;
    logic          overrun_q;
    logic          ack_err_q;
    logic          last_byte;
    logic          ack_expired;
    logic          gap_over;
    logic          byte_active;

    assign last_byte = (idx == 2'd3);

    // cnt is cleared on WAIT_ACK entry, so tx_start was cnt+1 cycles ago; leaving
    // on this cycle puts the ack_err pulse exactly ACK_TIMEOUT cycles after tx_start.
    assign ack_expired = (32'(cnt) + 32'd2) >= 32'(ACK_TIMEOUT);
    assign gap_over    = (32'(cnt) + 32'd1) >= 32'(GAP_CYCLES);

    always_comb begin
        if (last_byte)
            after_byte = FINISH;
        else if (GAP_CYCLES == 0)
            after_byte = START;
        else
            after_byte = GAP;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.result_valid) state_nxt = LATCH;
            LATCH:     state_nxt = START;
            START:     state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.tx_busy)
                    state_nxt = WAIT_DONE;
                else if (ack_expired)
                    state_nxt = after_byte;
            end
            WAIT_DONE: if (!bus.tx_busy) state_nxt = after_byte;
            GAP:       if (gap_over) state_nxt = START;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= '0;
            overrun_q <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            overrun_q <= bus.result_valid && (state != IDLE);
            ack_err_q <= (state == WAIT_ACK) && !bus.tx_busy && ack_expired;

            // Every START entry except the first one of a word advances to the next byte.
            if (state == LATCH)
                idx <= 2'd0;
            else if (state_nxt == START && idx != 2'd3)
                idx <= idx + 2'd1;

            if (state_nxt != state)
                cnt <= '0;
            else if ((state == WAIT_ACK || state == GAP) && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

`ifdef TX_SEQ_MSB_FIRST_EN
    assign sel = 2'd3 - idx;
`else
    assign sel = idx;
`endif

    assign byte_active = (state == START) || (state == WAIT_ACK) || (state == WAIT_DONE);

    always_comb begin
        send = 4'b0000;
        if (byte_active)
            send[sel] = 1'b1;
    end

    assign bus.send_b0           = send[0];
    assign bus.send_b1           = send[1];
    assign bus.send_b2           = send[2];
    assign bus.send_b3           = send[3];
    assign bus.register_result32 = (state == LATCH);
    assign bus.tx_start          = (state == START);
    assign bus.seq_busy          = (state != IDLE);
    assign bus.done              = (state == FINISH);
    assign bus.overrun           = overrun_q;
    assign bus.ack_err           = ack_err_q;
endmodule

// File: tb/tb_tx_byte_sequencer.sv
// Bench for tx_byte_sequencer: two instances (GAP_CYCLES=2 and 0), a UART busy model,
// an output-stage model and a byte scoreboard; table-driven words plus corner sequences.
module tb_tx_byte_sequencer;
    localparam int ACK_TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tx_byte_sequencer_if bus_a ();
    tx_byte_sequencer_if bus_b ();

    tx_byte_sequencer #(.GAP_CYCLES(2), .ACK_TIMEOUT(ACK_TO)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    tx_byte_sequencer #(.GAP_CYCLES(0), .ACK_TIMEOUT(ACK_TO)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

`ifdef TX_SEQ_MSB_FIRST_EN
    localparam logic [3:0] FIRST_SEL = 4'b1000;
`else
    localparam logic [3:0] FIRST_SEL = 4'b0001;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] sends_a();
        return {bus_a.send_b3, bus_a.send_b2, bus_a.send_b1, bus_a.send_b0};
    endfunction

    function automatic logic [9:0] outs_a();
        return {bus_a.register_result32, sends_a(), bus_a.tx_start, bus_a.seq_busy,
                bus_a.done, bus_a.overrun, bus_a.ack_err};
    endfunction

    function automatic logic [9:0] outs_b();
        return {bus_b.register_result32, bus_b.send_b3, bus_b.send_b2, bus_b.send_b1, bus_b.send_b0,
                bus_b.tx_start, bus_b.seq_busy, bus_b.done, bus_b.overrun, bus_b.ack_err};
    endfunction

    function automatic logic [7:0] pick(input logic [31:0] w, input logic [3:0] s);
        case (s)
            4'b0001: return w[7:0];
            4'b0010: return w[15:8];
            4'b0100: return w[23:16];
            4'b1000: return w[31:24];
            default: return 8'hxx;
        endcase
    endfunction

    // UART model: busy rises two cycles after a tx_start pulse and holds for busy_len cycles (0 = never).
    int   busy_len_a = 10;
    logic arm_a;
    int   bcnt_a;
    always @(posedge clk) begin
        if (reset) begin
            arm_a         <= 1'b0;
            bcnt_a        <= 0;
            bus_a.tx_busy <= 1'b0;
        end else begin
            arm_a <= bus_a.tx_start;
            if (arm_a && busy_len_a > 0) begin
                bus_a.tx_busy <= 1'b1;
                bcnt_a        <= busy_len_a;
            end else if (bus_a.tx_busy) begin
                if (bcnt_a <= 1) bus_a.tx_busy <= 1'b0;
                bcnt_a <= bcnt_a - 1;
            end
        end
    end

    logic arm_b;
    always @(posedge clk) begin
        if (reset) begin
            arm_b         <= 1'b0;
            bus_b.tx_busy <= 1'b0;
        end else begin
            arm_b         <= bus_b.tx_start;
            bus_b.tx_busy <= arm_b;
        end
    end

    // Output stage + scoreboard for instance a.
    logic [31:0] word_in_a;
    logic [31:0] out_word_a;
    logic [7:0]  exp_q[$];
    int starts_a = 0, acks_a = 0, ovr_a = 0, done_a = 0, regs_a = 0, last_start_a = 0;

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
`ifdef TX_SEQ_MSB_FIRST_EN
            exp_q.push_back(w[8*(3-i) +: 8]);
`else
            exp_q.push_back(w[8*i +: 8]);
`endif
        end
    endtask

    always @(negedge clk) begin
        if (bus_a.register_result32) begin
            out_word_a <= word_in_a;
            regs_a     <= regs_a + 1;
        end
        if (bus_a.tx_start) begin
            check("send_onehot", 32'($countones(sends_a())), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_byte: got 0x%0h with no byte expected (cycle %0d)",
                         pick(out_word_a, sends_a()), cyc);
            end else begin
                check("tx_byte", 32'(pick(out_word_a, sends_a())), 32'(exp_q.pop_front()));
            end
            last_start_a <= cyc;
            starts_a     <= starts_a + 1;
        end
        if (bus_a.ack_err) begin
            check("ack_err_delay", 32'(cyc - last_start_a), 32'(ACK_TO));
            acks_a <= acks_a + 1;
        end
        if (bus_a.overrun) ovr_a  <= ovr_a + 1;
        if (bus_a.done)    done_a <= done_a + 1;
    end

    int starts_b[$];
    int reg_b_cyc = 0;
    int acks_b = 0;
    always @(negedge clk) begin
        if (bus_b.register_result32) reg_b_cyc <= cyc;
        if (bus_b.tx_start)          starts_b.push_back(cyc);
        if (bus_b.ack_err)           acks_b <= acks_b + 1;
    end

    task automatic wait_done_a(input string nm);
        int n = 0;
        while (!bus_a.done && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus_a.done) begin
            errors++;
            $display("FAIL %s: done not seen within 500 cycles", nm);
        end
    endtask

    task automatic send_a(input logic [31:0] w);
        word_in_a = w;
        push_word(w);
        bus_a.result_valid = 1'b1;
        tick();
        bus_a.result_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] word;
        int          busy_len;
        int          rv2_delay;   // 0 = no second result_valid
        int          exp_starts;
        int          exp_acks;
        int          exp_ovr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int s0, a0, o0, d0, r0, n;

        vecs[0] = '{32'h1234_5678, 10, 0, 4, 0, 0};
        vecs[1] = '{32'hA5C3_0FF0,  3, 0, 4, 0, 0};
        vecs[2] = '{32'hDEAD_BEEF, 10, 5, 4, 0, 1};
        vecs[3] = '{32'h0BAD_F00D,  0, 0, 4, 4, 0};
        vecs[4] = '{32'h0000_0001,  1, 2, 4, 0, 1};

        reset = 1'b1;
        bus_a.result_valid = 1'b0;
        bus_b.result_valid = 1'b0;
        word_in_a = '0;
        tick(3);
        @(negedge clk);
        check("reset_outs_a", 32'(outs_a()), 32'd0);
        check("reset_outs_b", 32'(outs_b()), 32'd0);
        reset = 1'b0;
        tick(2);

        // First-transaction latency: strobe at N+1, tx_start with first byte selected at N+2.
        busy_len_a = 10;
        send_a(32'hCAFE_F00D);
        @(negedge clk);
        check("latch_strobe", 32'(bus_a.register_result32), 32'd1);
        check("no_early_start", 32'(bus_a.tx_start), 32'd0);
        @(negedge clk);
        check("first_start", 32'({bus_a.tx_start, sends_a()}), 32'({1'b1, FIRST_SEL}));
        wait_done_a("latency_done");
        tick(4);

        for (int v = 0; v < 5; v++) begin
            busy_len_a = vecs[v].busy_len;
            s0 = starts_a; a0 = acks_a; o0 = ovr_a; d0 = done_a;
            send_a(vecs[v].word);
            if (vecs[v].rv2_delay > 0) begin
                tick(vecs[v].rv2_delay - 1);
                word_in_a = 32'hFFFF_FFFF;
                bus_a.result_valid = 1'b1;
                tick();
                bus_a.result_valid = 1'b0;
            end
            wait_done_a("vec_done");
            tick(4);
            check("vec_starts",   32'(starts_a - s0), 32'(vecs[v].exp_starts));
            check("vec_ack_errs", 32'(acks_a - a0),   32'(vecs[v].exp_acks));
            check("vec_overruns", 32'(ovr_a - o0),    32'(vecs[v].exp_ovr));
            check("vec_done_cnt", 32'(done_a - d0),   32'd1);
            check("vec_sb_empty", 32'(exp_q.size()),  32'd0);
        end

        // result_valid during the FINISH cycle is an overrun, never a new word.
        busy_len_a = 2;
        send_a(32'h1357_9BDF);
        wait_done_a("finish_done");
        r0 = regs_a;
        bus_a.result_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_a.result_valid = 1'b0;
        @(negedge clk);
        check("finish_overrun", 32'(bus_a.overrun), 32'd1);
        check("finish_idle", 32'(bus_a.seq_busy), 32'd0);
        tick(3);
        check("finish_no_latch", 32'(regs_a - r0), 32'd0);

        // Reset during WAIT_DONE of byte 2 aborts; the next word starts again from byte 0.
        busy_len_a = 10;
        s0 = starts_a; d0 = done_a;
        send_a(32'h89AB_CDEF);
        n = 0;
        while (starts_a < s0 + 3 && n < 300) begin @(negedge clk); n++; end
        n = 0;
        while (!bus_a.tx_busy && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        check("wd_busy_before_rst", 32'(bus_a.seq_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_abort_outs", 32'(outs_a()), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick(2);
        check("rst_abort_starts", 32'(starts_a - s0), 32'd3);
        check("rst_abort_no_done", 32'(done_a - d0), 32'd0);
        s0 = starts_a; d0 = done_a;
        send_a(32'h2468_ACE0);
        wait_done_a("restart_done");
        tick(4);
        check("restart_starts", 32'(starts_a - s0), 32'd4);
        check("restart_done_cnt", 32'(done_a - d0), 32'd1);

        // result_valid coincident with reset is ignored.
        r0 = regs_a;
        reset = 1'b1;
        bus_a.result_valid = 1'b1;
        tick();
        reset = 1'b0;
        bus_a.result_valid = 1'b0;
        @(negedge clk);
        check("rst_rv_idle", 32'(bus_a.seq_busy), 32'd0);
        tick(2);
        check("rst_rv_no_latch", 32'(regs_a - r0), 32'd0);

        // GAP_CYCLES=0 with a one-cycle busy: starts spaced 4 cycles, strobe 1 cycle before first start.
        bus_b.result_valid = 1'b1;
        tick();
        bus_b.result_valid = 1'b0;
        n = 0;
        while (!bus_b.done && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!bus_b.done) begin
            errors++;
            $display("FAIL b_done: done not seen within 200 cycles");
        end
        tick(2);
        check("b_starts", 32'(starts_b.size()), 32'd4);
        if (starts_b.size() > 0)
            check("b_reg_to_start", 32'(starts_b[0] - reg_b_cyc), 32'd1);
        for (int i = 1; i < starts_b.size(); i++)
            check("b_start_spacing", 32'(starts_b[i] - starts_b[i-1]), 32'd4);
        check("b_ack_errs", 32'(acks_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tx_byte_sequencer.md
TX_BYTE_SEQUENCER -- requirements
Module: tx_byte_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 2, idle cycles inserted between consecutive bytes (0 allowed).
REQ-002 Parameter ACK_TIMEOUT, default 16, max cycles waiting for tx_busy to rise after tx_start (>=1).
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 result_valid  input  1  one-cycle pulse: 32-bit result ready at output stage.
REQ-006 tx_busy  input  1  UART transmitter busy flag.
REQ-007 register_result32  output  1  one-cycle strobe: output stage latches result word.
REQ-008 send_b0, send_b1, send_b2, send_b3  output  1 each  byte select toward output stage; at most one high.
REQ-009 tx_start  output  1  one-cycle UART start pulse.
REQ-010 seq_busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after last byte completes.
REQ-012 overrun  output  1  one-cycle pulse: result_valid seen while not IDLE.
REQ-013 ack_err  output  1  one-cycle pulse: ACK_TIMEOUT expired.

Function
REQ-014 FSM states SHALL be IDLE, LATCH, START, WAIT_ACK, WAIT_DONE, GAP, FINISH; all outputs Moore-registered or state-decoded, no combinational path from inputs to outputs.
REQ-015 IDLE: result_valid=1 -> LATCH; else stay.
REQ-016 LATCH: register_result32=1 for exactly one cycle; byte index cleared to 0; -> START.
REQ-017 START: tx_start=1 for exactly one cycle, selected send_bX=1; -> WAIT_ACK.
REQ-018 WAIT_ACK: tx_busy=1 -> WAIT_DONE; timeout counter reaching ACK_TIMEOUT -> ack_err pulse, treat byte as sent, go to GAP (or FINISH if last byte).
REQ-019 WAIT_DONE: tx_busy=0 -> GAP if byte index<3, else FINISH.
REQ-020 GAP: count GAP_CYCLES cycles (zero cycles when GAP_CYCLES=0, i.e. skip directly), increment byte index, -> START.
REQ-021 FINISH: done=1 for one cycle; -> IDLE.
REQ-022 send_bX for current byte SHALL stay asserted continuously from START through WAIT_DONE; deasserted in IDLE, LATCH, GAP, FINISH.
REQ-023 Default byte order SHALL be b0, b1, b2, b3 (LSB first).
REQ-024 Latency: result_valid at cycle N -> register_result32 at N+1 -> first tx_start at N+2.
REQ-025 result_valid while seq_busy=1 SHALL be dropped and pulse overrun next cycle; current sequence unaffected.
REQ-026 result_valid in FINISH cycle SHALL count as overrun (not queued).
REQ-027 tx_busy already high in START SHALL not shorten WAIT_ACK; WAIT_ACK samples from the cycle after tx_start.
REQ-028 Byte index and counters SHALL not wrap: index saturates at 3, counters clear on state entry.

Reset
REQ-029 reset=1 SHALL force IDLE from any state within one cycle, aborting any sequence.
REQ-030 Reset values: all outputs 0, byte index 0, all counters 0.
REQ-031 result_valid coincident with reset SHALL be ignored.

Configuration
REQ-032 Macro TX_SEQ_MSB_FIRST_EN: defined -> byte order b3, b2, b1, b0; undefined -> b0, b1, b2, b3; all timing identical in both builds.

Verification
REQ-033 Word 0x12345678, UART model busy 10 cycles after each start, GAP_CYCLES=2 -> tx_data bytes 0x78,0x56,0x34,0x12 in order, 4 tx_start pulses, one done, no ack_err.
REQ-034 Same stimulus with TX_SEQ_MSB_FIRST_EN defined -> bytes 0x12,0x34,0x56,0x78.
REQ-035 Second result_valid 5 cycles after first -> overrun pulse once, only 4 bytes sent, first word intact.
REQ-036 UART model never raises tx_busy, ACK_TIMEOUT=16 -> 4 ack_err pulses, each 16 cycles after its tx_start, done still pulses.
REQ-037 reset asserted in WAIT_DONE of byte 2 -> next cycle all outputs 0, IDLE; a new result_valid then restarts from byte 0.
REQ-038 GAP_CYCLES=0, busy 1 cycle -> tx_start pulses exactly 4 cycles apart, register_result32 exactly 1 cycle before first tx_start.
